// File: rtl/pad_mux_sequencer_pkg.sv
// Shared constants, register map and FSM state type for the pad mux sequencer.
// Imported by the register file and the top-level sequencer.
package pad_mux_sequencer_pkg;

   localparam logic [11:0] PAD_BASE    = 12'h000;
   localparam logic [11:0] COMMIT_OFFS = 12'h100;
   localparam logic [11:0] STATUS_OFFS = 12'h104;

   localparam int MUX_LSB         = 0;
   localparam int CFG_LSB         = 8;
   localparam int COMMIT_GO_BIT   = 0;
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATE   = 2'd1,
      ST_SWITCH = 2'd2,
      ST_HOLD   = 2'd3
   } seq_state_e;

   // Word-aligned offset that lands inside the pad register window.
   function automatic logic is_pad_addr(input logic [11:0] addr, input int n_io);
      logic [11:0] offs;
      offs = addr - PAD_BASE;
      return (offs[1:0] == 2'b00) && (int'(offs) < (4 * n_io));
   endfunction

endpackage

// File: rtl/pad_mux_sequencer_regs.sv
// APB decode plus shadow pad registers and sticky done flag.
// Exposes next-cycle shadow values so a copy sees writes landing on the same edge.
module pad_mux_sequencer_regs
   import pad_mux_sequencer_pkg::*;
#(
   parameter int N_IO        = 48,
   parameter int NBIT_PADCFG = 6,
   parameter int NBIT_MUX    = 2
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic [11:0]                         i_paddr,
   input  logic [31:0]                         i_pwdata,
   input  logic                                i_pwrite,
   input  logic                                i_psel,
   input  logic                                i_penable,
   input  logic                                i_busy,
   input  logic                                i_done_set,
   output logic [31:0]                         o_prdata,
   output logic                                o_pslverr,
   output logic                                o_commit,
   output logic [N_IO-1:0][NBIT_MUX-1:0]       o_shadow_mux_next,
   output logic [N_IO-1:0][NBIT_PADCFG-1:0]    o_shadow_cfg_next
);

   localparam int IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;

   logic [N_IO-1:0][NBIT_MUX-1:0]    r_mux;
   logic [N_IO-1:0][NBIT_MUX-1:0]    w_mux_nxt;
   logic [N_IO-1:0][NBIT_PADCFG-1:0] r_cfg;
   logic [N_IO-1:0][NBIT_PADCFG-1:0] w_cfg_nxt;
   logic                             r_done;
   logic                             w_done_nxt;
   logic [31:0]                      r_prdata;
   logic                             r_pslverr;
   logic [31:0]                      w_rdata;
   logic [11:0]                      w_offs;
   logic [IDX_W-1:0]                 w_idx;
   logic                             w_pad_hit;
   logic                             w_commit_hit;
   logic                             w_status_hit;
   logic                             w_setup;
   logic                             w_wr;
   logic                             w_err;
   logic                             w_unused;

   assign w_offs       = i_paddr - PAD_BASE;
   assign w_idx        = IDX_W'(w_offs[11:2]);
   assign w_pad_hit    = is_pad_addr(i_paddr, N_IO);
   assign w_commit_hit = (i_paddr == COMMIT_OFFS);
   assign w_status_hit = (i_paddr == STATUS_OFFS);
   assign w_setup      = i_psel & ~i_penable;
   assign w_wr         = i_psel & i_penable & i_pwrite;
   assign w_unused     = ^{i_pwdata, w_offs};

   // Error is decided in the setup phase so the registered response lines up with the access.
   assign w_err = ~(w_pad_hit | w_commit_hit | w_status_hit)
                | (w_commit_hit & i_pwrite & i_pwdata[COMMIT_GO_BIT] & i_busy);

   assign o_commit = w_wr & w_commit_hit & i_pwdata[COMMIT_GO_BIT] & ~i_busy & ~r_pslverr;

   // Read data mux for the register addressed in the setup phase.
   always_comb begin
      w_rdata = 32'h0000_0000;
      if (w_pad_hit) begin
         w_rdata[MUX_LSB +: NBIT_MUX]    = r_mux[w_idx];
         w_rdata[CFG_LSB +: NBIT_PADCFG] = r_cfg[w_idx];
      end else if (w_status_hit) begin
         w_rdata[STATUS_BUSY_BIT] = i_busy;
         w_rdata[STATUS_DONE_BIT] = r_done;
      end else begin
         w_rdata = 32'h0000_0000;
      end
   end

   // Shadow write and done flag next-state; a done set beats a same-cycle clear.
   always_comb begin
      w_mux_nxt  = r_mux;
      w_cfg_nxt  = r_cfg;
      w_done_nxt = r_done;
      if (w_wr && w_pad_hit) begin
         w_mux_nxt[w_idx] = i_pwdata[MUX_LSB +: NBIT_MUX];
         w_cfg_nxt[w_idx] = i_pwdata[CFG_LSB +: NBIT_PADCFG];
      end else begin
         w_mux_nxt = r_mux;
         w_cfg_nxt = r_cfg;
      end
      if (i_done_set) begin
         w_done_nxt = 1'b1;
      end else if (w_wr && w_status_hit && i_pwdata[STATUS_DONE_BIT]) begin
         w_done_nxt = 1'b0;
      end else begin
         w_done_nxt = r_done;
      end
   end

   // Register file and registered APB response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mux     <= '{default: '0};
         r_cfg     <= '{default: '0};
         r_done    <= 1'b0;
         r_prdata  <= 32'h0000_0000;
         r_pslverr <= 1'b0;
      end else begin
         r_mux     <= w_mux_nxt;
         r_cfg     <= w_cfg_nxt;
         r_done    <= w_done_nxt;
         r_prdata  <= (w_setup && !i_pwrite) ? w_rdata : 32'h0000_0000;
         r_pslverr <= w_setup & w_err;
      end
   end

   assign o_prdata          = r_prdata;
   assign o_pslverr         = r_pslverr;
   assign o_shadow_mux_next = w_mux_nxt;
   assign o_shadow_cfg_next = w_cfg_nxt;

endmodule

// File: rtl/pad_mux_sequencer.sv
// Pad mux commit sequencer: gates output enables around mux switches so two
// peripherals never drive the same pad, then applies shadow values atomically.
module pad_mux_sequencer
   import pad_mux_sequencer_pkg::*;
#(
   parameter int N_IO        = 48,
   parameter int NBIT_PADCFG = 6,
   parameter int NBIT_MUX    = 2,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [11:0]                     paddr_i,
   input  logic [31:0]                     pwdata_i,
   input  logic                            pwrite_i,
   input  logic                            psel_i,
   input  logic                            penable_i,
   output logic [31:0]                     prdata_o,
   output logic                            pready_o,
   output logic                            pslverr_o,
   output logic [N_IO*NBIT_MUX-1:0]        pad_mux_o,
   output logic [N_IO*NBIT_PADCFG-1:0]     pad_cfg_o,
   output logic [N_IO-1:0]                 oe_gate_o,
   output logic                            busy_o,
   output logic                            irq_o
);

   localparam int CNT_W = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

   seq_state_e                       r_state;
   seq_state_e                       w_state_nxt;
   logic [CNT_W-1:0]                 r_cnt;
   logic [CNT_W-1:0]                 w_cnt_nxt;
   logic [N_IO-1:0][NBIT_MUX-1:0]    r_active_mux;
   logic [N_IO-1:0][NBIT_MUX-1:0]    w_mux_nxt;
   logic [N_IO-1:0][NBIT_PADCFG-1:0] r_active_cfg;
   logic [N_IO-1:0][NBIT_PADCFG-1:0] w_cfg_nxt;
   logic [N_IO-1:0]                  r_gate;
   logic [N_IO-1:0]                  w_gate_nxt;
   logic                             r_busy;
   logic                             r_irq;
   logic                             w_irq_nxt;
   logic                             w_done_set;
   logic                             w_commit;
   logic [N_IO-1:0]                  w_change_mask;
   logic [N_IO-1:0][NBIT_MUX-1:0]    w_shadow_mux;
   logic [N_IO-1:0][NBIT_PADCFG-1:0] w_shadow_cfg;

   pad_mux_sequencer_regs #(
      .N_IO        (N_IO),
      .NBIT_PADCFG (NBIT_PADCFG),
      .NBIT_MUX    (NBIT_MUX)
   ) u_regs (
      .i_clk             (clk_i),
      .i_rst_n           (rst_ni),
      .i_paddr           (paddr_i),
      .i_pwdata          (pwdata_i),
      .i_pwrite          (pwrite_i),
      .i_psel            (psel_i),
      .i_penable         (penable_i),
      .i_busy            (r_busy),
      .i_done_set        (w_done_set),
      .o_prdata          (prdata_o),
      .o_pslverr         (pslverr_o),
      .o_commit          (w_commit),
      .o_shadow_mux_next (w_shadow_mux),
      .o_shadow_cfg_next (w_shadow_cfg)
   );

   // Pads whose mux select differs between shadow and active.
   always_comb begin
      w_change_mask = {N_IO{1'b0}};
      for (int n = 0; n < N_IO; n++) begin
         w_change_mask[n] = (w_shadow_mux[n] != r_active_mux[n]);
      end
   end

   // Sequencer next state. SWITCH sits on the last gap cycle so new values
   // appear exactly GAP_CYCLES cycles after the commit.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mux_nxt   = r_active_mux;
      w_cfg_nxt   = r_active_cfg;
      w_gate_nxt  = r_gate;
      w_irq_nxt   = 1'b0;
      w_done_set  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_commit) begin
               if (w_change_mask == {N_IO{1'b0}}) begin
                  w_mux_nxt  = w_shadow_mux;
                  w_cfg_nxt  = w_shadow_cfg;
                  w_irq_nxt  = 1'b1;
                  w_done_set = 1'b1;
               end else begin
                  w_gate_nxt  = r_gate & ~w_change_mask;
                  w_cnt_nxt   = CNT_RELOAD;
                  w_state_nxt = (GAP_CYCLES == 1) ? ST_SWITCH : ST_GATE;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GATE: begin
            if (r_cnt <= CNT_ONE) begin
               w_cnt_nxt   = CNT_ZERO;
               w_state_nxt = ST_SWITCH;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         ST_SWITCH: begin
            w_mux_nxt   = w_shadow_mux;
            w_cfg_nxt   = w_shadow_cfg;
            w_cnt_nxt   = CNT_RELOAD;
            w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (r_cnt == CNT_ZERO) begin
               w_gate_nxt  = {N_IO{1'b1}};
               w_irq_nxt   = 1'b1;
               w_done_set  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_gate_nxt  = {N_IO{1'b1}};
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counter, active pad values and registered status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_IDLE;
         r_cnt        <= CNT_ZERO;
         r_active_mux <= '{default: '0};
         r_active_cfg <= '{default: '0};
         r_gate       <= {N_IO{1'b1}};
         r_busy       <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_active_mux <= w_mux_nxt;
         r_active_cfg <= w_cfg_nxt;
         r_gate       <= w_gate_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_irq        <= w_irq_nxt;
      end
   end

   assign pready_o  = 1'b1;
   assign pad_mux_o = r_active_mux;
   assign pad_cfg_o = r_active_cfg;
   assign oe_gate_o = r_gate;
   assign busy_o    = r_busy;
   assign irq_o     = r_irq;

endmodule

// File: tb/tb_pad_mux_sequencer.sv
// Directed bench for pad_mux_sequencer: register-map vector table plus
// cycle-exact windows around gated commits, busy commits and mid-sequence reset.
module tb_pad_mux_sequencer;

   localparam int N_IO = 48;
   localparam int NCFG = 6;
   localparam int NMUX = 2;
   localparam int G    = 4;

   logic                   clk_i;
   logic                   rst_ni;
   logic [11:0]            paddr_i;
   logic [31:0]            pwdata_i;
   logic                   pwrite_i;
   logic                   psel_i;
   logic                   penable_i;
   logic [31:0]            prdata_o;
   logic                   pready_o;
   logic                   pslverr_o;
   logic [N_IO*NMUX-1:0]   pad_mux_o;
   logic [N_IO*NCFG-1:0]   pad_cfg_o;
   logic [N_IO-1:0]        oe_gate_o;
   logic                   busy_o;
   logic                   irq_o;

   int checks = 0;
   int errors = 0;

   pad_mux_sequencer #(
      .N_IO(N_IO), .NBIT_PADCFG(NCFG), .NBIT_MUX(NMUX), .GAP_CYCLES(G)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
      .pwrite_i(pwrite_i), .psel_i(psel_i), .penable_i(penable_i),
      .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
      .pad_mux_o(pad_mux_o), .pad_cfg_o(pad_cfg_o), .oe_gate_o(oe_gate_o),
      .busy_o(busy_o), .irq_o(irq_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[18];

   logic       cap_gate   [1:10];
   logic [1:0] cap_mux    [1:10];
   logic       cap_irq    [1:10];
   logic       cap_busy   [1:10];
   logic       cap_others [1:10];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Caller is just after a rising edge; setup phase starts now, returns just after the access edge.
   task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = d;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      @(negedge clk_i);
      rd  = prdata_o;
      err = pslverr_o;
      @(posedge clk_i); #1;
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
   endtask

   task automatic capture(input int p, input int n);
      for (int j = 1; j <= n; j++) begin
         @(negedge clk_i);
         cap_gate[j]   = oe_gate_o[p];
         cap_mux[j]    = pad_mux_o[p*NMUX +: NMUX];
         cap_irq[j]    = irq_o;
         cap_busy[j]   = busy_o;
         cap_others[j] = ((oe_gate_o | (48'd1 << p)) == {N_IO{1'b1}});
      end
   endtask

   task automatic check_window(input string tag, input logic [1:0] old_m, input logic [1:0] new_m);
      for (int j = 1; j <= 10; j++) begin
         check($sformatf("%s_gate_c%0d", tag, j), 64'(cap_gate[j]), 64'((j <= 2*G) ? 1'b0 : 1'b1));
         check($sformatf("%s_mux_c%0d", tag, j), 64'(cap_mux[j]), 64'((j >= G+1) ? new_m : old_m));
         check($sformatf("%s_irq_c%0d", tag, j), 64'(cap_irq[j]), 64'(j == 2*G+1));
         check($sformatf("%s_busy_c%0d", tag, j), 64'(cap_busy[j]), 64'(j <= 2*G));
         check($sformatf("%s_others_c%0d", tag, j), 64'(cap_others[j]), 64'd1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gate"}, 64'(oe_gate_o), 64'hFFFF_FFFF_FFFF);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_irq"}, 64'(irq_o), 64'd0);
      check({tag, "_mux"}, 64'(|pad_mux_o), 64'd0);
      check({tag, "_cfg"}, 64'(|pad_cfg_o), 64'd0);
      check({tag, "_prdata"}, 64'(prdata_o), 64'd0);
      check({tag, "_pslverr"}, 64'(pslverr_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        err;

      vecs[0]  = '{1'b0, 12'h014, 32'h0,         32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 12'h104, 32'h0,         32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b1, 12'h00C, 32'h0000_0A00, 32'h0,         1'b0};
      vecs[3]  = '{1'b0, 12'h00C, 32'h0,         32'h0000_0A00, 1'b0};
      vecs[4]  = '{1'b1, 12'h028, 32'hFFFF_FFFF, 32'h0,         1'b0};
      vecs[5]  = '{1'b0, 12'h028, 32'h0,         32'h0000_3F03, 1'b0};
      vecs[6]  = '{1'b1, 12'h028, 32'h0,         32'h0,         1'b0};
      vecs[7]  = '{1'b0, 12'h028, 32'h0,         32'h0000_0000, 1'b0};
      vecs[8]  = '{1'b0, 12'h200, 32'h0,         32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b1, 12'h200, 32'hFFFF_FFFF, 32'h0,         1'b1};
      vecs[10] = '{1'b0, 12'h0C0, 32'h0,         32'h0000_0000, 1'b1};
      vecs[11] = '{1'b0, 12'h00E, 32'h0,         32'h0000_0000, 1'b1};
      vecs[12] = '{1'b1, 12'h100, 32'h0,         32'h0,         1'b0};
      vecs[13] = '{1'b0, 12'h100, 32'h0,         32'h0000_0000, 1'b0};
      vecs[14] = '{1'b0, 12'h0BC, 32'h0,         32'h0000_0000, 1'b0};
      vecs[15] = '{1'b1, 12'h0BC, 32'h0000_0003, 32'h0,         1'b0};
      vecs[16] = '{1'b0, 12'h0BC, 32'h0,         32'h0000_0003, 1'b0};
      vecs[17] = '{1'b1, 12'h0BC, 32'h0,         32'h0,         1'b0};

      rst_ni = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
      paddr_i = 12'h000; pwdata_i = 32'h0;
      repeat (2) @(negedge clk_i);
      check_reset_outputs("reset");
      check("reset_pready", 64'(pready_o), 64'd1);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      for (int i = 0; i < 18; i++) begin
         apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
         check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
         if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
         check($sformatf("vec%0d_noirq", i), 64'(irq_o), 64'd0);
         check($sformatf("vec%0d_nobusy", i), 64'(busy_o), 64'd0);
      end
      check("shadow_not_active", 64'(pad_cfg_o[3*NCFG +: NCFG]), 64'd0);

      // Fast path: config-only change on pad 3.
      apb(1'b1, 12'h100, 32'h1, rd, err);
      @(negedge clk_i);
      check("fast_cfg3_c1", 64'(pad_cfg_o[3*NCFG +: NCFG]), 64'h0A);
      check("fast_irq_c1", 64'(irq_o), 64'd1);
      check("fast_busy_c1", 64'(busy_o), 64'd0);
      check("fast_gate_c1", 64'(oe_gate_o), 64'hFFFF_FFFF_FFFF);
      @(negedge clk_i);
      check("fast_irq_c2", 64'(irq_o), 64'd0);
      check("fast_busy_c2", 64'(busy_o), 64'd0);
      @(posedge clk_i); #1;
      apb(1'b0, 12'h104, 32'h0, rd, err);
      check("fast_status_done", 64'(rd), 64'h2);
      apb(1'b1, 12'h104, 32'h2, rd, err);
      apb(1'b0, 12'h104, 32'h0, rd, err);
      check("status_w1c", 64'(rd), 64'h0);

      // Gated commit on pad 7 with a rejected commit while busy.
      apb(1'b1, 12'h01C, 32'h2, rd, err);
      apb(1'b1, 12'h100, 32'h1, rd, err);
      fork
         capture(7, 10);
         begin
            logic [31:0] rd2;
            logic        err2;
            apb(1'b1, 12'h100, 32'h1, rd2, err2);
            check("busy_commit_err", 64'(err2), 64'd1);
         end
      join
      @(posedge clk_i); #1;
      check_window("runA", 2'd0, 2'd2);
      apb(1'b0, 12'h104, 32'h0, rd, err);
      check("runA_status", 64'(rd), 64'h2);
      apb(1'b1, 12'h104, 32'h2, rd, err);

      // Shadow write during GATE is picked up by the switch.
      apb(1'b1, 12'h01C, 32'h1, rd, err);
      apb(1'b1, 12'h100, 32'h1, rd, err);
      fork
         capture(7, 10);
         begin
            logic [31:0] rd3;
            logic        err3;
            apb(1'b1, 12'h01C, 32'h3, rd3, err3);
            check("gate_write_err", 64'(err3), 64'd0);
         end
      join
      @(posedge clk_i); #1;
      check_window("runB", 2'd2, 2'd3);

      // Reset in the middle of a gated commit on pad 20.
      apb(1'b1, 12'h050, 32'h1, rd, err);
      apb(1'b1, 12'h100, 32'h1, rd, err);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check("midrst_gate20_c3", 64'(oe_gate_o[20]), 64'd0);
      check("midrst_busy_c3", 64'(busy_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      apb(1'b0, 12'h050, 32'h0, rd, err);
      check("midrst_shadow20", 64'(rd), 64'h0);
      apb(1'b0, 12'h104, 32'h0, rd, err);
      check("midrst_status", 64'(rd), 64'h0);
      apb(1'b1, 12'h050, 32'h1, rd, err);
      apb(1'b1, 12'h100, 32'h1, rd, err);
      capture(20, 10);
      check_window("runC", 2'd0, 2'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
